// File: rtl/stage1_dict_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stage1_dict_ctrl
// Description : Stage-1 dictionary compression controller. Latches a source
//               word, presents it with a 16-entry dictionary to an external
//               comparator, registers the returned code and appends unmatched
//               non-zero words to the dictionary (round-robin replacement).
//               Optional statistics counters: define STAGE1_DICT_CTRL_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module stage1_dict_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [31:0]  in_word,
    output logic         in_ready,
    input  logic         flush,
    output logic [31:0]  cmp_word_o,
    output logic [511:0] cmp_dict_o,
    input  logic [11:0]  cmp_code_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [11:0]  out_code,
    output logic         out_miss,
    output logic [31:0]  out_word,
    output logic [4:0]   dict_count
`ifdef STAGE1_DICT_CTRL_STATS_EN
    ,
    output logic [15:0]  hit_cnt,
    output logic [15:0]  miss_cnt,
    output logic [15:0]  zero_cnt
`endif
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CMP  = 2'd1;
    localparam logic [1:0] c_OUT  = 2'd2;

    localparam logic [4:0] c_DICT_FULL = 5'd16;

    logic [1:0]  r_state;
    logic [31:0] r_dict [16];
    logic [3:0]  r_wr_ptr;
    logic [4:0]  r_count;
    logic [31:0] r_cmp_word;
    logic [11:0] r_out_code;
    logic        r_out_miss;
    logic [31:0] r_out_word;

    logic        w_zero;
    logic        w_miss;
    logic        w_hit;

    // Classification of the word currently in CMP.
    assign w_zero = (r_cmp_word == 32'd0);
    assign w_miss = (cmp_code_i == 12'd0) && !w_zero;
    assign w_hit  = (cmp_code_i[11:8] == 4'b1101) && !w_zero;

    assign in_ready   = (r_state == c_IDLE) && !flush;
    assign out_valid  = (r_state == c_OUT);
    assign cmp_word_o = r_cmp_word;
    assign out_code   = r_out_code;
    assign out_miss   = r_out_miss;
    assign out_word   = r_out_word;
    assign dict_count = r_count;

    // Entry k of the dictionary drives bits [32k+31:32k] of the flat bus.
    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_dict
            assign cmp_dict_o[32*g +: 32] = r_dict[g];
        end
    endgenerate

    // Main controller: IDLE -> CMP -> OUT, dictionary update on a miss.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_wr_ptr   <= 4'd0;
            r_count    <= 5'd0;
            r_cmp_word <= 32'd0;
            r_out_code <= 12'd0;
            r_out_miss <= 1'b0;
            r_out_word <= 32'd0;
            for (int k = 0; k < 16; k++) begin
                r_dict[k] <= 32'd0;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (flush) begin
                        r_wr_ptr <= 4'd0;
                        r_count  <= 5'd0;
                        for (int k = 0; k < 16; k++) begin
                            r_dict[k] <= 32'd0;
                        end
                    end else if (in_valid) begin
                        r_cmp_word <= in_word;
                        r_state    <= c_CMP;
                    end
                end
                c_CMP: begin
                    r_out_code <= cmp_code_i;
                    r_out_word <= r_cmp_word;
                    r_out_miss <= w_miss;
                    if (w_miss) begin
                        r_dict[r_wr_ptr] <= r_cmp_word;
                        r_wr_ptr         <= r_wr_ptr + 4'd1;
                        if (r_count != c_DICT_FULL) begin
                            r_count <= r_count + 5'd1;
                        end
                    end
                    r_state <= c_OUT;
                end
                c_OUT: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef STAGE1_DICT_CTRL_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;
    logic [15:0] r_zero_cnt;

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
    assign zero_cnt = r_zero_cnt;

    // Saturating per-class counters; a zero word is counted only as zero.
    always_ff @(posedge clk) begin
        if (reset || (r_state == c_IDLE && flush)) begin
            r_hit_cnt  <= 16'd0;
            r_miss_cnt <= 16'd0;
            r_zero_cnt <= 16'd0;
        end else if (r_state == c_CMP) begin
            if (w_zero) begin
                if (r_zero_cnt != 16'hFFFF) r_zero_cnt <= r_zero_cnt + 16'd1;
            end else if (w_miss) begin
                if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
            end else if (w_hit) begin
                if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stage1_dict_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage1_dict_ctrl
// Description : Self-checking bench for stage1_dict_ctrl with a transaction-
//               level dictionary model and per-cycle output comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage1_dict_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [31:0]  in_word;
    logic         in_ready;
    logic         flush;
    logic [31:0]  cmp_word_o;
    logic [511:0] cmp_dict_o;
    logic [11:0]  cmp_code_i;
    logic         out_valid;
    logic         out_ready;
    logic [11:0]  out_code;
    logic         out_miss;
    logic [31:0]  out_word;
    logic [4:0]   dict_count;

    always #5 clk = ~clk;

    stage1_dict_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_word    (in_word),
        .in_ready   (in_ready),
        .flush      (flush),
        .cmp_word_o (cmp_word_o),
        .cmp_dict_o (cmp_dict_o),
        .cmp_code_i (cmp_code_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .out_miss   (out_miss),
        .out_word   (out_word),
        .dict_count (dict_count)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Transaction-level model: phase 0 = waiting, 1 = comparing, 2 = result held.
    logic [31:0] m_dict [16];
    logic [3:0]  m_ptr;
    logic [4:0]  m_count;
    logic [31:0] m_cmp_word;
    int          m_phase;
    logic [11:0] m_code;
    logic        m_miss;
    logic [31:0] m_word;
    bit          chk_en = 1'b0;

    logic [11:0] got_code;
    logic        got_miss;
    logic [31:0] got_word;

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) m_dict[k] = 32'd0;
        m_ptr      = 4'd0;
        m_count    = 5'd0;
        m_cmp_word = 32'd0;
        m_phase    = 0;
        m_code     = 12'd0;
        m_miss     = 1'b0;
        m_word     = 32'd0;
    endtask

    function automatic logic [511:0] m_flat();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[32*k +: 32] = m_dict[k];
        return v;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready, (m_phase == 0) && !flush);
            check("out_valid", out_valid, m_phase == 2);
            if (m_phase == 2) begin
                check("out_code", out_code, m_code);
                check("out_miss", out_miss, m_miss);
                check("out_word", out_word, m_word);
            end
            check("cmp_word_o", cmp_word_o, m_cmp_word);
            check("dict_count", dict_count, m_count);
            check("cmp_dict_o", cmp_dict_o, m_flat());
        end
    end

    // One word through the controller; called at posedge+1 with the DUT idle.
    task automatic send(input logic [31:0] w, input logic [11:0] c,
                        input int hold, input bit flush_in_out);
        in_valid   = 1'b1;
        in_word    = w;
        cmp_code_i = c;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_word    = $urandom;
        m_cmp_word = w;
        m_phase    = 1;
        @(posedge clk); #1;
        cmp_code_i = 12'($urandom);
        m_phase    = 2;
        m_code     = c;
        m_word     = w;
        m_miss     = (c == 12'd0) && (w != 32'd0);
        if (m_miss) begin
            m_dict[m_ptr] = w;
            m_ptr         = m_ptr + 4'd1;
            if (m_count < 5'd16) m_count = m_count + 5'd1;
        end
        got_code = out_code;
        got_miss = out_miss;
        got_word = out_word;
        for (int h = 0; h < hold; h++) begin
            if (flush_in_out && h == 1) flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        m_phase   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_word    = 32'd0;
        flush      = 1'b0;
        cmp_code_i = 12'd0;
        out_ready  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset state, hand-computed.
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_code", out_code, 12'h000);
        check("rst_out_miss", out_miss, 1'b0);
        check("rst_out_word", out_word, 32'h0);
        check("rst_cmp_word", cmp_word_o, 32'h0);
        check("rst_dict_count", dict_count, 5'd0);
        check("rst_dict", cmp_dict_o, 512'h0);
        check("rst_in_ready", in_ready, 1'b1);

        // First miss lands in entry 0.
        send(32'h12345678, 12'h000, 0, 1'b0);
        check("m1_miss", got_miss, 1'b1);
        check("m1_word", got_word, 32'h12345678);
        check("m1_entry0", cmp_dict_o[31:0], 32'h12345678);
        check("m1_count", dict_count, 5'd1);

        // Zero word: not a literal, dictionary untouched.
        send(32'h00000000, 12'h000, 0, 1'b0);
        check("z_miss", got_miss, 1'b0);
        check("z_code", got_code, 12'h000);
        check("z_count", dict_count, 5'd1);

        // Hit code passes through, no write.
        send(32'hCAFEBABE, 12'hD56, 0, 1'b0);
        check("h_code", got_code, 12'hD56);
        check("h_miss", got_miss, 1'b0);
        check("h_count", dict_count, 5'd1);

        // Non-zero, non-hit code: not a miss either.
        send(32'hDEADBEEF, 12'h123, 0, 1'b0);
        check("p_miss", got_miss, 1'b0);

        // Stalled output with a flush pulse in OUT; miss goes to entry 1.
        send(32'h0BADF00D, 12'h000, 5, 1'b1);
        check("s_entry1", cmp_dict_o[63:32], 32'h0BADF00D);
        check("s_count", dict_count, 5'd2);

        // Flush and in_valid together in IDLE: clear, word refused.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_word  = 32'h55555555;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) m_dict[k] = 32'd0;
        m_ptr   = 4'd0;
        m_count = 5'd0;
        check("f_out_valid", out_valid, 1'b0);
        check("f_count", dict_count, 5'd0);
        check("f_dict", cmp_dict_o, 512'h0);

        // 17 consecutive misses: wrap to entry 0, count saturates.
        for (int i = 1; i <= 17; i++) send(32'h10000000 + 32'(i), 12'h000, 0, 1'b0);
        check("w_entry0", cmp_dict_o[31:0], 32'h10000011);
        check("w_entry1_old", cmp_dict_o[63:32], 32'h10000002);
        check("w_count", dict_count, 5'd16);
        send(32'hABCD0001, 12'h000, 0, 1'b0);
        check("w_entry1", cmp_dict_o[63:32], 32'hABCD0001);
        check("w_count_sat", dict_count, 5'd16);

        // Reset during CMP discards the in-flight word.
        in_valid   = 1'b1;
        in_word    = 32'h77777777;
        cmp_code_i = 12'h000;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        m_cmp_word = 32'h77777777;
        m_phase    = 1;
        reset      = 1'b1;
        @(posedge clk); #1;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        check("r_out_valid", out_valid, 1'b0);
        check("r_count", dict_count, 5'd0);
        check("r_dict", cmp_dict_o, 512'h0);

        // Normal operation resumes from entry 0.
        send(32'h0000ABCD, 12'h000, 2, 1'b0);
        check("a_entry0", cmp_dict_o[31:0], 32'h0000ABCD);
        check("a_count", dict_count, 5'd1);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
